rdma_pkt_arb: RTL

- Packet-aware two-requester arbiter in front of qp_context.
- Merges the host request stream and the rx (rdma_rx output) stream into one valid/ready/last stream.
- A grant is held from first beat to `last`, so packets never interleave.
- Round-robin fairness, per-source backpressure and a registered output stage give qp_context a clean single source.

---
 rtl/rdma_arb_pkg.sv | 16 +
 rtl/rdma_out_reg.sv | 40 ++++
 rtl/rdma_pkt_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rdma_arb_pkg.sv
// Shared types and constants for the rdma_pkt_arb packet arbiter.
package rdma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_HOST = 2'd1,
    LOCK_RX   = 2'd2
  } state_t;

  localparam logic SRC_HOST = 1'b0;
  localparam logic SRC_RX   = 1'b1;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_MAX_BEATS = 256;

endpackage

// File: rtl/rdma_out_reg.sv
// One-slot registered valid/ready output stage carrying data, last and source.
// load is exported so the arbiter can offer ready upstream in the same cycle.
module rdma_out_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_src,
  output logic              load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src
);

  // Slot can take a new beat when empty or when its beat leaves this cycle.
  assign load = ~out_valid | out_ready;

  // Register slot; payload only updates when a real beat arrives so it holds stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
        out_src  <= in_src;
      end
    end
  end

endmodule

// File: rtl/rdma_pkt_arb.sv
// Packet-aware host/rx round-robin arbiter feeding qp_context through a
// registered output slot. A grant is held from first beat to last; packets
// longer than MAX_BEATS are cut with a forced last and an overrun pulse.
// Optional macro RDMA_ARB_WEIGHT_EN: host may win HOST_WEIGHT consecutive
// contended packets before rx is forced.
module rdma_pkt_arb
  import rdma_arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_BEATS   = DEF_MAX_BEATS,
  parameter int HOST_WEIGHT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = $clog2(MAX_BEATS);

  if (MAX_BEATS < 2 || HOST_WEIGHT < 1) begin : g_bad_param
    $error("rdma_pkt_arb: MAX_BEATS must be >= 2 and HOST_WEIGHT >= 1");
  end

  state_t            state, state_nxt;
  logic              load;
  logic              rr_ptr, rr_nxt;
  logic [CW-1:0]     beat_cnt;
  logic              sel_host, sel_rx;
  logic              acc, acc_src, acc_last, cnt_hit, pkt_end, grant;
  logic [DATA_W-1:0] acc_data;
  logic              ovr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: lock on a non-final first beat, release at packet end.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (acc && !pkt_end) state_nxt = (acc_src == SRC_RX) ? LOCK_RX : LOCK_HOST;
      LOCK_HOST, LOCK_RX:
        if (pkt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pick the serviced source and gate its ready with the slot load.
  always_comb begin
    sel_host = 1'b0;
    sel_rx   = 1'b0;
    case (state)
      IDLE: begin
        sel_host = host_valid & (~rx_valid | (rr_ptr == SRC_HOST));
        sel_rx   = rx_valid & ~sel_host;
      end
      LOCK_HOST: sel_host = 1'b1;
      LOCK_RX:   sel_rx   = 1'b1;
      default: ;
    endcase
    host_ready = sel_host & load;
    rx_ready   = sel_rx & load;
  end

  assign acc_src  = sel_rx ? SRC_RX : SRC_HOST;
  assign acc      = (host_valid & host_ready) | (rx_valid & rx_ready);
  assign acc_last = sel_rx ? rx_last : host_last;
  assign acc_data = sel_rx ? rx_data : host_data;
  // Non-final beat that would be beat MAX_BEATS gets cut here.
  assign cnt_hit  = acc & ~acc_last & (beat_cnt == CW'(MAX_BEATS - 1));
  assign pkt_end  = acc & (acc_last | cnt_hit);
  assign grant    = acc & (state == IDLE);
  assign busy     = (state != IDLE);
  assign overrun  = ovr_q;

`ifdef RDMA_ARB_WEIGHT_EN
  localparam int WCW = $clog2(HOST_WEIGHT + 1);
  logic [WCW-1:0] weight_cnt, w_now;

  // Weight count including this cycle's grant, so single-beat packets see it.
  always_comb begin
    w_now = weight_cnt;
    if (grant) begin
      if (acc_src == SRC_HOST && rx_valid)
        w_now = (weight_cnt >= WCW'(HOST_WEIGHT)) ? weight_cnt : weight_cnt + 1'b1;
      else
        w_now = '0;
    end
    rr_nxt = (acc_src == SRC_RX) ? SRC_HOST :
             ((w_now >= WCW'(HOST_WEIGHT)) ? SRC_RX : SRC_HOST);
  end

  // Consecutive contended host grants.
  always_ff @(posedge clk) begin
    if (rst) weight_cnt <= '0;
    else     weight_cnt <= w_now;
  end
`else
  assign rr_nxt = ~acc_src;
`endif

  // Round-robin pointer, beat counter and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= SRC_HOST;
      beat_cnt <= '0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= cnt_hit;
      if (pkt_end) begin
        rr_ptr   <= rr_nxt;
        beat_cnt <= '0;
      end else if (acc) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  rdma_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc),
    .in_data   (acc_data),
    .in_last   (acc_last | cnt_hit),
    .in_src    (acc_src),
    .load      (load),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src)
  );

endmodule
